// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if
//   Signal bundle between the processor/stream side and io_port_bridge.
//   slave  : the bridge (consumes OUT/IN strobes and rx stream, drives tx stream, status)
//   master : the environment (processor write-back/IN logic plus the stream devices)
//   Groups: OUT path (out_wr, out_data, out_full), tx stream (tx_valid, tx_data, tx_ready),
//           rx stream (rx_valid, rx_data, rx_ready), IN path (in_rd, in_data, in_empty),
//           error flags (err_clr, ovf_err, udf_err).
interface io_port_bridge_if #(
  parameter int DATA_W = 16
);
  logic              out_wr;
  logic [DATA_W-1:0] out_data;
  logic              out_full;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              in_rd;
  logic [DATA_W-1:0] in_data;
  logic              in_empty;
  logic              err_clr;
  logic              ovf_err;
  logic              udf_err;

  modport slave (
    input  out_wr, out_data, tx_ready, rx_valid, rx_data, in_rd, err_clr,
    output out_full, tx_valid, tx_data, rx_ready, in_data, in_empty, ovf_err, udf_err
  );

  modport master (
    output out_wr, out_data, tx_ready, rx_valid, rx_data, in_rd, err_clr,
    input  out_full, tx_valid, tx_data, rx_ready, in_data, in_empty, ovf_err, udf_err
  );
endinterface

// File: rtl/io_port_bridge.sv
// io_port_bridge
//   Bridges the processor 16-bit IN/OUT ports to valid/ready streaming devices.
//   OUT words queue in an output FIFO draining over tx; rx words queue in an input
//   FIFO read by IN instructions. Sticky ovf_err/udf_err flag dropped OUT words and
//   IN reads issued while empty.
//   Ports: clk, reset (async, active low), bus (io_port_bridge_if.slave).
//   Every output is derived from registers only; no input-to-output comb path.

// io_port_fifo
//   Circular FIFO with first-word-fall-through head. push/pop arrive already
//   qualified by the caller, so overflow/underflow policy lives in the top.
//   Ports: clk, reset, push, pop, wData in; head (0 when empty), empty, full out.
module io_port_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wData,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rPtr, wPtr;
  logic [AW:0]   count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rPtr  <= '0;
      wPtr  <= '0;
      count <= '0;
    end else begin
      if (push) wPtr <= wPtr + 1'b1;
      if (pop)  rPtr <= rPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the empty mask on head hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wPtr] <= wData;
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = empty ? '0 : mem[rPtr];
endmodule

module io_port_bridge #(
  parameter int DATA_W    = 16,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
) (
  input logic              clk,
  input logic              reset,
  io_port_bridge_if.slave  bus
);
  logic              outPush, outPop, outEmpty, outFull;
  logic              inPush, inPop, inEmpty, inFull;
  logic [DATA_W-1:0] outHead, inHead;
  logic              ovfSet, udfSet;
  logic              ovfErr, udfErr;

  // Output side: a pop frees a slot in the same cycle, so a full FIFO still
  // accepts out_wr when tx drains; only an unabsorbed write is an overflow.
  assign outPop  = !outEmpty && bus.tx_ready;
  assign outPush = bus.out_wr && (!outFull || outPop);
  assign ovfSet  = bus.out_wr && outFull && !outPop;

  // Input side: rx_ready depends on state only, so a coincident IN read never
  // opens a slot for the arriving word; an empty FIFO never bypasses rx_data.
  assign inPush = bus.rx_valid && !inFull;
  assign inPop  = bus.in_rd && !inEmpty;
  assign udfSet = bus.in_rd && inEmpty;

  io_port_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) uOutFifo (
    .clk   (clk),
    .reset (reset),
    .push  (outPush),
    .pop   (outPop),
    .wData (bus.out_data),
    .head  (outHead),
    .empty (outEmpty),
    .full  (outFull)
  );

  io_port_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) uInFifo (
    .clk   (clk),
    .reset (reset),
    .push  (inPush),
    .pop   (inPop),
    .wData (bus.rx_data),
    .head  (inHead),
    .empty (inEmpty),
    .full  (inFull)
  );

  // Sticky flags: a set event wins over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovfErr <= 1'b0;
      udfErr <= 1'b0;
    end else begin
      if (ovfSet)           ovfErr <= 1'b1;
      else if (bus.err_clr) ovfErr <= 1'b0;
      if (udfSet)           udfErr <= 1'b1;
      else if (bus.err_clr) udfErr <= 1'b0;
    end
  end

  assign bus.out_full = outFull;
  assign bus.tx_valid = !outEmpty;
  assign bus.tx_data  = outHead;
  assign bus.rx_ready = !inFull;
  assign bus.in_empty = inEmpty;
  assign bus.in_data  = inHead;
  assign bus.ovf_err  = ovfErr;
  assign bus.udf_err  = udfErr;
endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge
//   Directed bench for io_port_bridge (DATA_W=16, both depths 4). Inputs change
//   1 time unit after each rising edge; outputs are sampled at that point too.
module tb_io_port_bridge;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  io_port_bridge_if #(.DATA_W(16)) bif ();

  io_port_bridge #(.DATA_W(16), .OUT_DEPTH(4), .IN_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp4 [4];
    int sent;
    int rcv;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bif.out_wr = 1'b0; bif.out_data = '0; bif.tx_ready = 1'b0;
    bif.rx_valid = 1'b0; bif.rx_data = '0; bif.in_rd = 1'b0; bif.err_clr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_tx_valid", bif.tx_valid, 0);
    chk("rst_tx_data",  bif.tx_data,  0);
    chk("rst_out_full", bif.out_full, 0);
    chk("rst_rx_ready", bif.rx_ready, 1);
    chk("rst_in_empty", bif.in_empty, 1);
    chk("rst_in_data",  bif.in_data,  0);
    chk("rst_ovf",      bif.ovf_err,  0);
    chk("rst_udf",      bif.udf_err,  0);
    reset = 1'b1;

    // Output ordering with backpressure
    bif.out_wr = 1'b1; bif.out_data = 16'h1111; step();
    chk("ord_lat_valid", bif.tx_valid, 1);
    chk("ord_lat_data",  bif.tx_data,  16'h1111);
    bif.out_data = 16'h2222; step();
    bif.out_data = 16'h3333; step();
    bif.out_wr = 1'b0;
    chk("ord_stall1", bif.tx_data, 16'h1111);
    step();
    chk("ord_stall2", bif.tx_data, 16'h1111);
    bif.tx_ready = 1'b1;
    chk("ord_d0", bif.tx_data, 16'h1111); step();
    chk("ord_d1", bif.tx_data, 16'h2222); step();
    chk("ord_d2", bif.tx_data, 16'h3333); step();
    chk("ord_empty", bif.tx_valid, 0);
    chk("ord_empty_data", bif.tx_data, 0);
    bif.tx_ready = 1'b0;

    // Overflow, flag priority, full with simultaneous push+pop
    for (int i = 0; i < 4; i++) begin
      bif.out_wr = 1'b1; bif.out_data = 16'h00A0 + 16'(i); step();
    end
    bif.out_wr = 1'b0;
    chk("ovf_full", bif.out_full, 1);
    bif.out_wr = 1'b1; bif.out_data = 16'hDEAD; bif.err_clr = 1'b1; step();
    bif.out_wr = 1'b0; bif.err_clr = 1'b0;
    chk("ovf_set_over_clr", bif.ovf_err, 1);
    chk("ovf_still_full", bif.out_full, 1);
    bif.err_clr = 1'b1; step(); bif.err_clr = 1'b0;
    chk("ovf_cleared", bif.ovf_err, 0);
    bif.out_wr = 1'b1; bif.out_data = 16'hBEEF; bif.tx_ready = 1'b1; step();
    bif.out_wr = 1'b0; bif.tx_ready = 1'b0;
    chk("fullpp_full", bif.out_full, 1);
    chk("fullpp_noovf", bif.ovf_err, 0);
    exp4[0] = 16'h00A1; exp4[1] = 16'h00A2; exp4[2] = 16'h00A3; exp4[3] = 16'hBEEF;
    bif.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), bif.tx_data, exp4[i]);
      step();
    end
    bif.tx_ready = 1'b0;
    chk("ovf_drained", bif.tx_valid, 0);

    // Pointer wrap: 10 words, random consumer
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      bif.out_wr   = (sent < 10) && !bif.out_full;
      bif.out_data = 16'h0100 + 16'(sent);
      bif.tx_ready = 1'($urandom_range(0, 1));
      if (bif.tx_valid && bif.tx_ready) begin
        chk($sformatf("wrap_w%0d", rcv), bif.tx_data, 16'h0100 + 16'(rcv));
        rcv++;
      end
      if (bif.out_wr) sent++;
      step();
    end
    bif.out_wr = 1'b0; bif.tx_ready = 1'b0;
    chk("wrap_count", rcv, 10);
    chk("wrap_empty", bif.tx_valid, 0);

    // Input path and underflow
    bif.rx_valid = 1'b1; bif.rx_data = 16'h0A0A; step();
    chk("in_lat_empty", bif.in_empty, 0);
    chk("in_lat_data",  bif.in_data,  16'h0A0A);
    bif.rx_data = 16'h0B0B; step();
    bif.rx_valid = 1'b0;
    bif.in_rd = 1'b1;
    chk("in_rd0", bif.in_data, 16'h0A0A); step();
    chk("in_rd1", bif.in_data, 16'h0B0B); step();
    chk("in_rd2_data", bif.in_data, 0);
    chk("in_rd2_empty", bif.in_empty, 1);
    chk("in_rd2_noudf", bif.udf_err, 0);
    step();
    bif.in_rd = 1'b0;
    chk("udf_set", bif.udf_err, 1);
    chk("udf_still_empty", bif.in_empty, 1);
    bif.err_clr = 1'b1; step(); bif.err_clr = 1'b0;
    chk("udf_cleared", bif.udf_err, 0);

    // Input full: rx_ready drops only at 4 words, no push while full
    for (int i = 0; i < 4; i++) begin
      bif.rx_valid = 1'b1; bif.rx_data = 16'h00C0 + 16'(i);
      chk($sformatf("in_rdy%0d", i), bif.rx_ready, 1);
      step();
    end
    bif.rx_valid = 1'b0;
    chk("in_full_rdy", bif.rx_ready, 0);
    chk("in_full_head", bif.in_data, 16'h00C0);
    bif.rx_valid = 1'b1; bif.rx_data = 16'h00EE; bif.in_rd = 1'b1; step();
    bif.rx_valid = 1'b0;
    chk("in_fullpp_rdy", bif.rx_ready, 1);
    chk("in_d1", bif.in_data, 16'h00C1); step();
    chk("in_d2", bif.in_data, 16'h00C2); step();
    chk("in_d3", bif.in_data, 16'h00C3); step();
    bif.in_rd = 1'b0;
    chk("in_noEE", bif.in_empty, 1);

    // No bypass on read-while-empty with coincident arrival
    bif.rx_valid = 1'b1; bif.rx_data = 16'h0077; bif.in_rd = 1'b1;
    chk("nobyp_data", bif.in_data, 0);
    step();
    bif.rx_valid = 1'b0; bif.in_rd = 1'b0;
    chk("nobyp_udf", bif.udf_err, 1);
    chk("nobyp_kept", bif.in_data, 16'h0077);

    // Mid-stream reset with 3 words in each FIFO
    bif.rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.out_wr = 1'b1; bif.out_data = 16'h0051 + 16'(i);
      bif.rx_data = 16'h0078 + 16'(i);
      if (i == 2) bif.rx_valid = 1'b0;
      step();
    end
    bif.out_wr = 1'b0; bif.rx_valid = 1'b0;
    chk("pre_rst_valid", bif.tx_valid, 1);
    reset = 1'b0;
    #2;
    chk("mrst_tx_valid", bif.tx_valid, 0);
    chk("mrst_tx_data",  bif.tx_data,  0);
    chk("mrst_in_empty", bif.in_empty, 1);
    chk("mrst_rx_ready", bif.rx_ready, 1);
    chk("mrst_in_data",  bif.in_data,  0);
    chk("mrst_udf",      bif.udf_err,  0);
    chk("mrst_ovf",      bif.ovf_err,  0);
    reset = 1'b1;
    step();
    bif.out_wr = 1'b1; bif.out_data = 16'h5555;
    bif.rx_valid = 1'b1; bif.rx_data = 16'h6666;
    step();
    bif.out_wr = 1'b0; bif.rx_valid = 1'b0;
    chk("post_rst_tx", bif.tx_data, 16'h5555);
    chk("post_rst_in", bif.in_data, 16'h6666);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
